// File: rtl/demux_1to4_buf.sv
// Buffered 1-to-4 demultiplexer: one valid/ready input stream is steered by
// select_i into one of four independent DEPTH-entry FIFOs.
module demux_1to4_buf #(
  parameter int unsigned size  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [size-1:0]          data_i,
  input  logic [1:0]               select_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [size-1:0]          data0_o,
  output logic [size-1:0]          data1_o,
  output logic [size-1:0]          data2_o,
  output logic [size-1:0]          data3_o,
  output logic                     valid0_o,
  output logic                     valid1_o,
  output logic                     valid2_o,
  output logic                     valid3_o,
  input  logic                     ready0_i,
  input  logic                     ready1_i,
  input  logic                     ready2_i,
  input  logic                     ready3_i,
  output logic [$clog2(DEPTH):0]   count0_o,
  output logic [$clog2(DEPTH):0]   count1_o,
  output logic [$clog2(DEPTH):0]   count2_o,
  output logic [$clog2(DEPTH):0]   count3_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [size-1:0] r_mem    [4][DEPTH];
  logic [PW-1:0]   r_wr_ptr [4];
  logic [PW-1:0]   r_rd_ptr [4];
  logic [CW-1:0]   r_count  [4];

  logic [3:0] w_rdy;
  logic [3:0] w_valid;
  logic [3:0] w_push;
  logic [3:0] w_pop;

  assign w_rdy = {ready3_i, ready2_i, ready1_i, ready0_i};

  // A full channel still accepts when its head leaves in the same cycle.
  assign ready_o = rst_i & ((r_count[select_i] < CW'(DEPTH)) | w_rdy[select_i]);

  always_comb begin
    w_valid = '0;
    w_push  = '0;
    w_pop   = '0;
    for (int n = 0; n < 4; n++) begin
      w_valid[n] = (r_count[n] != '0);
      w_pop[n]   = w_valid[n] & w_rdy[n];
      w_push[n]  = valid_i & ready_o & (select_i == 2'(n));
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int n = 0; n < 4; n++) begin
        r_wr_ptr[n] <= '0;
        r_rd_ptr[n] <= '0;
        r_count[n]  <= '0;
        for (int e = 0; e < DEPTH; e++) begin
          r_mem[n][e] <= '0;
        end
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (w_push[n]) begin
          r_mem[n][r_wr_ptr[n]] <= data_i;
          r_wr_ptr[n]           <= r_wr_ptr[n] + PW'(1);
        end
        if (w_pop[n]) begin
          r_rd_ptr[n] <= r_rd_ptr[n] + PW'(1);
        end
        case ({w_push[n], w_pop[n]})
          2'b10:   r_count[n] <= r_count[n] + CW'(1);
          2'b01:   r_count[n] <= r_count[n] - CW'(1);
          default: r_count[n] <= r_count[n];
        endcase
      end
    end
  end

  assign data0_o  = r_mem[0][r_rd_ptr[0]];
  assign data1_o  = r_mem[1][r_rd_ptr[1]];
  assign data2_o  = r_mem[2][r_rd_ptr[2]];
  assign data3_o  = r_mem[3][r_rd_ptr[3]];
  assign valid0_o = w_valid[0];
  assign valid1_o = w_valid[1];
  assign valid2_o = w_valid[2];
  assign valid3_o = w_valid[3];
  assign count0_o = r_count[0];
  assign count1_o = r_count[1];
  assign count2_o = r_count[2];
  assign count3_o = r_count[3];

`ifndef SYNTHESIS
  // Simulation-only sanity: legal select while valid, occupancy bounded.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if (valid_i) begin
        assert (!$isunknown(select_i)) else $error("select_i unknown while valid_i=1");
      end
      for (int n = 0; n < 4; n++) begin
        assert (r_count[n] <= CW'(DEPTH)) else $error("channel %0d count above DEPTH", n);
      end
    end
  end
`endif

endmodule
